// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t RESET_PC = 32'hBFC0_0000;
  localparam word_t PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    word_t instr;
    word_t pc;
    word_t pcplus4;
    logic  adel;
    logic  valid;
  } fetch_bundle_t;

  // Sequential PC, wraps modulo 2^32.
  function automatic word_t pc_next(input word_t pc);
    return word_t'(pc + PC_STEP);
  endfunction

  // Instruction fetch requires word alignment.
  function automatic logic pc_misaligned(input word_t pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// SRAM-like instruction bus: one request, address handshake, data handshake.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic  inst_req;
  word_t inst_addr;
  logic  inst_addr_ok;
  logic  inst_data_ok;
  word_t inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/fetch_stage_skid_buf.sv
// One-entry word buffer that parks a returned instruction while decode stalls.
module fetch_skid_buf
  import fetch_stage_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load_i,
  input  logic  drain_i,
  input  logic  flush_i,
  input  word_t data_i,
  output word_t data_o,
  output logic  valid_o
);

  word_t data_q, data_d;
  logic  valid_q, valid_d;

  // Flush and drain both empty the entry; load only fills when neither applies.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush_i || drain_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end
  end

  // Buffer storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, runs one read at a time on the instruction bus,
// absorbs decode stalls and redirects, and registers the bundle for decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = fetch_stage_pkg::RESET_PC
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  fetch_stage_pkg::word_t redirect_pc,
  fetch_stage_if.master          ibus,
  output logic                   d_valid,
  output fetch_stage_pkg::word_t d_instr,
  output fetch_stage_pkg::word_t d_pc,
  output fetch_stage_pkg::word_t d_pcplus4,
  output logic                   d_adel
);
  import fetch_stage_pkg::*;

  fetch_state_t  state_q, state_d;
  word_t         pc_q, pc_d;
  logic          discard_q, discard_d;
  logic          req_q, req_d;
  fetch_bundle_t d_q, d_d;

  logic  buf_load, buf_drain, buf_flush;
  word_t buf_data;
  logic  buf_valid;

  word_t pc_inc;
  logic  pc_bad;
  logic  addr_acc;

  assign pc_inc   = pc_next(pc_q);
  assign pc_bad   = pc_misaligned(pc_q);
  assign addr_acc = req_q && ibus.inst_addr_ok;

  fetch_skid_buf u_skid (
    .clk     (clk),
    .reset   (reset),
    .load_i  (buf_load),
    .drain_i (buf_drain),
    .flush_i (buf_flush),
    .data_i  (ibus.inst_rdata),
    .data_o  (buf_data),
    .valid_o (buf_valid)
  );

  // Next state, PC, discard flag and decode bundle; redirect overrides everything.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    d_d       = d_q;
    buf_load  = 1'b0;
    buf_drain = 1'b0;
    buf_flush = 1'b0;

    // Decode consumed the bundle and nothing new arrives unless overwritten below.
    if (!stall) d_d.valid = 1'b0;

    if (redirect_valid) begin
      pc_d      = redirect_pc;
      d_d.valid = 1'b0;
      buf_flush = 1'b1;
      unique case (state_q)
        REQ: begin
          // An accepted request still returns data that must be swallowed.
          if (addr_acc) begin
            discard_d = 1'b1;
            state_d   = WAIT;
          end
        end
        WAIT: begin
          if (ibus.inst_data_ok) begin
            discard_d = 1'b0;
            state_d   = REQ;
          end else begin
            discard_d = 1'b1;
          end
        end
        HOLD:    state_d = REQ;
        default: state_d = REQ;
      endcase
    end else begin
      unique case (state_q)
        REQ: begin
          if (pc_bad) begin
            // Report the address error and park until an exception redirect.
            if (!stall) begin
              d_d = '{instr: '0, pc: pc_q, pcplus4: pc_inc, adel: 1'b1, valid: 1'b1};
            end
          end else if (addr_acc) begin
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (ibus.inst_data_ok) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = REQ;
            end else if (!stall) begin
              d_d     = '{instr: ibus.inst_rdata, pc: pc_q, pcplus4: pc_inc,
                          adel: 1'b0, valid: 1'b1};
              pc_d    = pc_inc;
              state_d = REQ;
            end else begin
              buf_load = 1'b1;
              state_d  = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall && buf_valid) begin
            d_d       = '{instr: buf_data, pc: pc_q, pcplus4: pc_inc,
                          adel: 1'b0, valid: 1'b1};
            pc_d      = pc_inc;
            buf_drain = 1'b1;
            state_d   = REQ;
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  // Request is registered so it stays low until the first edge after reset.
  assign req_d = (state_d == REQ) && !pc_misaligned(pc_d);

  // Stage state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= REQ;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      req_q     <= 1'b0;
      d_q       <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      req_q     <= req_d;
      d_q       <= d_d;
    end
  end

  assign ibus.inst_req  = req_q;
  assign ibus.inst_addr = pc_q;

  assign d_valid   = d_q.valid;
  assign d_instr   = d_q.instr;
  assign d_pc      = d_q.pc;
  assign d_pcplus4 = d_q.pcplus4;
  assign d_adel    = d_q.adel;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small latency-programmable bus responder.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic  clk;
  logic  reset;
  logic  stall;
  logic  redirect_valid;
  word_t redirect_pc;
  logic  d_valid;
  word_t d_instr;
  word_t d_pc;
  word_t d_pcplus4;
  logic  d_adel;

  fetch_stage_if ibus ();

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ibus           (ibus),
    .d_valid        (d_valid),
    .d_instr        (d_instr),
    .d_pc           (d_pc),
    .d_pcplus4      (d_pcplus4),
    .d_adel         (d_adel)
  );

  int n_cmp;
  int n_err;

  // Responder controls.
  logic  hold_ok;
  int    lat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: word at BFC0_0000 is 2408_0001, then ascending.
  function automatic word_t instr_of(input word_t a);
    return word_t'(32'h2408_0001 + (a - 32'hBFC0_0000));
  endfunction

  // Bus responder: grants requests unless hold_ok, returns data lat+1 cycles later.
  logic  mem_wait;
  int    mem_cnt;
  word_t mem_addr;
  logic  req_last;
  word_t addr_last;
  initial begin
    ibus.inst_addr_ok = 1'b0;
    ibus.inst_data_ok = 1'b0;
    ibus.inst_rdata   = '0;
    mem_wait  = 1'b0;
    mem_cnt   = 0;
    mem_addr  = '0;
    req_last  = 1'b0;
    addr_last = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        mem_wait          = 1'b0;
        req_last          = 1'b0;
        ibus.inst_addr_ok = 1'b0;
        ibus.inst_data_ok = 1'b0;
      end else begin
        if (ibus.inst_data_ok) mem_wait = 1'b0;
        if (ibus.inst_addr_ok && req_last) begin
          mem_wait = 1'b1;
          mem_cnt  = lat;
          mem_addr = addr_last;
        end
        ibus.inst_data_ok = 1'b0;
        if (mem_wait) begin
          if (mem_cnt == 0) begin
            ibus.inst_data_ok = 1'b1;
            ibus.inst_rdata   = instr_of(mem_addr);
          end else begin
            mem_cnt = mem_cnt - 1;
          end
        end
        ibus.inst_addr_ok = !hold_ok && ibus.inst_req && !mem_wait;
        req_last  = ibus.inst_req;
        addr_last = ibus.inst_addr;
      end
    end
  end

  // Assert reset for two cycles and release it at a falling edge.
  task automatic do_reset(input logic hold, input int latency);
    reset          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    hold_ok        = hold;
    lat            = latency;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Bounded wait for a valid bundle.
  task automatic wait_valid(input string nm);
    for (int i = 0; i < 50 && !d_valid; i++) @(negedge clk);
    n_cmp++;
    if (d_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s_timeout: d_valid=%b want 1", nm, d_valid);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    hold_ok = 1'b0; lat = 0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({d_valid, d_adel, d_pc, d_instr, d_pcplus4, ibus.inst_req} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%b adel=%b pc=%h instr=%h p4=%h req=%b want zeros",
               d_valid, d_adel, d_pc, d_instr, d_pcplus4, ibus.inst_req);
    end
    n_cmp++;
    if (ibus.inst_addr !== 32'hBFC0_0000) begin
      n_err++;
      $display("FAIL reset_addr: got %h want bfc00000", ibus.inst_addr);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (ibus.inst_req !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_req: got %b want 0", ibus.inst_req);
    end
    @(negedge clk);
    n_cmp++;
    if (ibus.inst_req !== 1'b1 || ibus.inst_addr !== 32'hBFC0_0000) begin
      n_err++;
      $display("FAIL first_req: req=%b addr=%h want 1 bfc00000", ibus.inst_req, ibus.inst_addr);
    end
    @(negedge clk);
    n_cmp++;
    if (d_valid !== 1'b0 || ibus.inst_req !== 1'b0) begin
      n_err++;
      $display("FAIL first_wait: valid=%b req=%b want 0 0", d_valid, ibus.inst_req);
    end
    @(negedge clk);
    n_cmp++;
    if (d_valid !== 1'b1 || d_pc !== 32'hBFC0_0000 || d_pcplus4 !== 32'hBFC0_0004 ||
        d_instr !== 32'h2408_0001 || d_adel !== 1'b0) begin
      n_err++;
      $display("FAIL first_word: valid=%b pc=%h p4=%h instr=%h adel=%b want 1 bfc00000 bfc00004 24080001 0",
               d_valid, d_pc, d_pcplus4, d_instr, d_adel);
    end
  endtask

  task automatic test_straight_line;
    int    k;
    int    last_cyc;
    logic  prev_v;
    word_t exp_pc;
    do_reset(1'b0, 2);
    k = 0; last_cyc = -1; prev_v = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (d_valid) begin
        exp_pc = word_t'(32'hBFC0_0000 + 32'(k) * 32'd4);
        n_cmp++;
        if (prev_v !== 1'b0 || d_pc !== exp_pc || d_instr !== instr_of(exp_pc)) begin
          n_err++;
          $display("FAIL line_word%0d: prev_valid=%b pc=%h instr=%h want 0 %h %h",
                   k, prev_v, d_pc, d_instr, exp_pc, instr_of(exp_pc));
        end
        if (last_cyc >= 0) begin
          n_cmp++;
          if (cyc - last_cyc != 4) begin
            n_err++;
            $display("FAIL line_gap%0d: got %0d want 4", k, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        k++;
      end
      prev_v = d_valid;
    end
    n_cmp++;
    if (k < 4) begin
      n_err++;
      $display("FAIL line_count: got %0d want >=4", k);
    end
  endtask

  task automatic test_stall;
    do_reset(1'b0, 2);
    wait_valid("stall_pre");
    stall = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c <= 5) begin
        n_cmp++;
        if (d_valid !== 1'b1 || d_pc !== 32'hBFC0_0000 || ibus.inst_req !== 1'b0) begin
          n_err++;
          $display("FAIL stall_freeze_c%0d: valid=%b pc=%h req=%b want 1 bfc00000 0",
                   c, d_valid, d_pc, ibus.inst_req);
        end
      end
      if (c == 5) stall = 1'b0;
      if (c == 6) begin
        n_cmp++;
        if (d_valid !== 1'b1 || d_pc !== 32'hBFC0_0004 || d_instr !== instr_of(32'hBFC0_0004) ||
            ibus.inst_req !== 1'b1 || ibus.inst_addr !== 32'hBFC0_0008) begin
          n_err++;
          $display("FAIL stall_release: valid=%b pc=%h instr=%h req=%b addr=%h want 1 bfc00004 %h 1 bfc00008",
                   d_valid, d_pc, d_instr, ibus.inst_req, ibus.inst_addr, instr_of(32'hBFC0_0004));
        end
      end
      if (c == 7) begin
        n_cmp++;
        if (d_valid !== 1'b0) begin
          n_err++;
          $display("FAIL stall_no_dup: valid=%b want 0", d_valid);
        end
      end
    end
  endtask

  // at=0: redirect with the accepting addr_ok; at=1: redirect during WAIT.
  task automatic redirect_case(input string nm, input int at, input word_t tgt);
    do_reset(1'b0, 2);
    wait_valid(nm);
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (c <= 7) begin
          n_cmp++;
          if (d_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_dropped_c%0d: valid=%b pc=%h want 0", nm, c, d_valid, d_pc);
          end
        end
        if (c <= 3) begin
          n_cmp++;
          if (ibus.inst_req !== 1'b0) begin
            n_err++;
            $display("FAIL %s_noreq_c%0d: req=%b want 0", nm, c, ibus.inst_req);
          end
        end
        if (c == 4) begin
          n_cmp++;
          if (ibus.inst_req !== 1'b1 || ibus.inst_addr !== tgt) begin
            n_err++;
            $display("FAIL %s_newreq: req=%b addr=%h want 1 %h", nm, ibus.inst_req, ibus.inst_addr, tgt);
          end
        end
        if (c == 8) begin
          n_cmp++;
          if (d_valid !== 1'b1 || d_pc !== tgt || d_instr !== instr_of(tgt)) begin
            n_err++;
            $display("FAIL %s_target_word: valid=%b pc=%h instr=%h want 1 %h %h",
                     nm, d_valid, d_pc, d_instr, tgt, instr_of(tgt));
          end
        end
      end
      redirect_valid = (c == at);
      redirect_pc    = tgt;
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_redirect_wait;
    redirect_case("redir_wait", 1, 32'h8000_0180);
  endtask

  task automatic test_redirect_accept;
    redirect_case("redir_accept", 0, 32'h8000_0200);
  endtask

  task automatic test_redirect_noaccept;
    do_reset(1'b1, 0);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    hold_ok        = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_cmp++;
    if (ibus.inst_req !== 1'b1 || ibus.inst_addr !== 32'h8000_0300) begin
      n_err++;
      $display("FAIL redir_noacc_addr: req=%b addr=%h want 1 80000300", ibus.inst_req, ibus.inst_addr);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (d_valid !== 1'b1 || d_pc !== 32'h8000_0300 || d_instr !== instr_of(32'h8000_0300)) begin
      n_err++;
      $display("FAIL redir_noacc_word: valid=%b pc=%h instr=%h want 1 80000300 %h",
               d_valid, d_pc, d_instr, instr_of(32'h8000_0300));
    end
  endtask

  task automatic test_misaligned;
    do_reset(1'b1, 0);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hBFC0_0002;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_cmp++;
    if (ibus.inst_req !== 1'b0 || d_valid !== 1'b0) begin
      n_err++;
      $display("FAIL adel_first: req=%b valid=%b want 0 0", ibus.inst_req, d_valid);
    end
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if (d_valid !== 1'b1 || d_adel !== 1'b1 || d_instr !== 32'h0 || d_pc !== 32'hBFC0_0002 ||
          d_pcplus4 !== 32'hBFC0_0006 || ibus.inst_req !== 1'b0) begin
        n_err++;
        $display("FAIL adel_c%0d: valid=%b adel=%b instr=%h pc=%h p4=%h req=%b want 1 1 0 bfc00002 bfc00006 0",
                 c, d_valid, d_adel, d_instr, d_pc, d_pcplus4, ibus.inst_req);
      end
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'hBFC0_0010;
    hold_ok        = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_cmp++;
    if (d_valid !== 1'b0 || ibus.inst_req !== 1'b1 || ibus.inst_addr !== 32'hBFC0_0010) begin
      n_err++;
      $display("FAIL adel_exit: valid=%b req=%b addr=%h want 0 1 bfc00010",
               d_valid, ibus.inst_req, ibus.inst_addr);
    end
  endtask

  task automatic test_wrap;
    do_reset(1'b1, 0);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    hold_ok        = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_cmp++;
    if (ibus.inst_req !== 1'b1 || ibus.inst_addr !== 32'hFFFF_FFFC) begin
      n_err++;
      $display("FAIL wrap_req: req=%b addr=%h want 1 fffffffc", ibus.inst_req, ibus.inst_addr);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (d_valid !== 1'b1 || d_pc !== 32'hFFFF_FFFC || d_pcplus4 !== 32'h0 || ibus.inst_addr !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_word: valid=%b pc=%h p4=%h addr=%h want 1 fffffffc 0 0",
               d_valid, d_pc, d_pcplus4, ibus.inst_addr);
    end
  endtask

  task automatic test_reset_mid;
    do_reset(1'b0, 2);
    wait_valid("midrst_pre");
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (d_valid !== 1'b0 || d_pc !== 32'h0 || ibus.inst_req !== 1'b0 || ibus.inst_addr !== 32'hBFC0_0000) begin
      n_err++;
      $display("FAIL midrst_async: valid=%b pc=%h req=%b addr=%h want 0 0 0 bfc00000",
               d_valid, d_pc, ibus.inst_req, ibus.inst_addr);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_valid("midrst_post");
    n_cmp++;
    if (d_pc !== 32'hBFC0_0000 || d_instr !== 32'h2408_0001) begin
      n_err++;
      $display("FAIL midrst_restart: pc=%h instr=%h want bfc00000 24080001", d_pc, d_instr);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_straight_line();
    test_stall();
    test_redirect_wait();
    test_redirect_accept();
    test_redirect_noaccept();
    test_misaligned();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
